pipeline_stall_controller: RTL and testbench

Central hazard and stall sequencer for the five-stage RV32IM pipeline. It issues per-register hold and flush controls to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Its inputs are memory busywaits, load-use hazards, taken branches resolved in EX, and the multi-cycle divider. It replaces the practice of wiring raw busywait signals straight into each pipeline register.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/load_use_detector.sv | 24 ++
 rtl/pipeline_stall_controller.sv | 144 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: stall-sequencer state encoding and the
// bubble instruction loaded by pipeline registers on a flush.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV      = 2'd1,
        DIV_DONE = 2'd2
    } stall_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID;
// x0 is never a real dependency.
module load_use_detector #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
        hazard  = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central hold/flush sequencer for the five-stage pipeline: DMEM freeze,
// multi-cycle divide, taken branch, load-use bubble and fetch stall.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IMEM_BUSYWAIT,
    input  logic                  DMEM_BUSYWAIT,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic [REG_ADDR_W-1:0] EX_RD,
    input  logic                  EX_MEM_READ,
    input  logic                  EX_BRANCH_TAKEN,
    input  logic                  EX_DIV_START,
    output logic                  PC_HOLD,
    output logic                  IF_ID_HOLD,
    output logic                  ID_EX_HOLD,
    output logic                  EX_MEM_HOLD,
    output logic                  MEM_WB_HOLD,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EX_FLUSH,
    output logic                  EX_MEM_FLUSH,
    output logic                  DIV_BUSY
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    stall_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             discard_q, discard_d;

    logic load_use;
    logic div_stall;
    logic discard_now;

    load_use_detector #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
        .id_rs1      (ID_RS1),
        .id_rs2      (ID_RS2),
        .id_uses_rs1 (ID_USES_RS1),
        .id_uses_rs2 (ID_USES_RS2),
        .ex_rd       (EX_RD),
        .ex_mem_read (EX_MEM_READ),
        .hazard      (load_use)
    );

    always_comb begin
        // DIV_DONE deliberately ignores EX_DIV_START so the finishing divide cannot re-trigger
        div_stall   = (state_q == DIV) || ((state_q == RUN) && EX_DIV_START);
        discard_now = discard_q && !IMEM_BUSYWAIT;

        PC_HOLD      = 1'b0;
        IF_ID_HOLD   = 1'b0;
        ID_EX_HOLD   = 1'b0;
        EX_MEM_HOLD  = 1'b0;
        MEM_WB_HOLD  = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_FLUSH = 1'b0;
        DIV_BUSY     = !RESET && div_stall;

        if (RESET) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_FLUSH  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
        end else if (DMEM_BUSYWAIT) begin
            PC_HOLD     = 1'b1;
            IF_ID_HOLD  = 1'b1;
            ID_EX_HOLD  = 1'b1;
            EX_MEM_HOLD = 1'b1;
            MEM_WB_HOLD = 1'b1;
        end else begin
            if (div_stall) begin
                PC_HOLD      = 1'b1;
                IF_ID_HOLD   = 1'b1;
                ID_EX_HOLD   = 1'b1;
                EX_MEM_FLUSH = 1'b1;
            end else if (EX_BRANCH_TAKEN) begin
                IF_ID_FLUSH = 1'b1;
                ID_EX_FLUSH = 1'b1;
            end else if (load_use) begin
                PC_HOLD     = 1'b1;
                IF_ID_HOLD  = 1'b1;
                ID_EX_FLUSH = 1'b1;
            end else if (IMEM_BUSYWAIT) begin
                PC_HOLD    = 1'b1;
                IF_ID_HOLD = 1'b1;
            end
            // The late wrong-path fetch word is squashed; the flush overrides any IF/ID hold
            if (discard_now) begin
                IF_ID_FLUSH = 1'b1;
                IF_ID_HOLD  = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        if (!DMEM_BUSYWAIT) begin
            case (state_q)
                RUN: begin
                    if (EX_DIV_START) begin
                        state_d = DIV;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end
                end
                DIV: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DIV_DONE;
                    end
                end
                DIV_DONE: state_d = RUN;
                default:  state_d = RUN;
            endcase

            if (!div_stall && EX_BRANCH_TAKEN && IMEM_BUSYWAIT) begin
                discard_d = 1'b1;
            end else if (discard_now) begin
                discard_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus randomized traffic,
// all compared against a remaining-stall-cycles reference model.
module tb_pipeline_stall_controller;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem, dmem, br, start, mr, u1, u2;
    logic [4:0] rd, rs1, rs2;
    logic       pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, div_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    pipeline_stall_controller #(.DIV_CYCLES(DC), .REG_ADDR_W(5)) dut (
        .CLK             (clk),
        .RESET           (rst),
        .IMEM_BUSYWAIT   (imem),
        .DMEM_BUSYWAIT   (dmem),
        .ID_RS1          (rs1),
        .ID_RS2          (rs2),
        .ID_USES_RS1     (u1),
        .ID_USES_RS2     (u2),
        .EX_RD           (rd),
        .EX_MEM_READ     (mr),
        .EX_BRANCH_TAKEN (br),
        .EX_DIV_START    (start),
        .PC_HOLD         (pc_hold),
        .IF_ID_HOLD      (if_id_hold),
        .ID_EX_HOLD      (id_ex_hold),
        .EX_MEM_HOLD     (ex_mem_hold),
        .MEM_WB_HOLD     (mem_wb_hold),
        .IF_ID_FLUSH     (if_id_flush),
        .ID_EX_FLUSH     (id_ex_flush),
        .EX_MEM_FLUSH    (ex_mem_flush),
        .DIV_BUSY        (div_busy)
    );

    always #5 clk = ~clk;

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB holds, IF_ID, ID_EX, EX_MEM flushes, DIV_BUSY}
    logic [8:0] obs;
    assign obs = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold,
                  if_id_flush, id_ex_flush, ex_mem_flush, div_busy};

    // Reference model: stall cycles still owed by the divider, a "divide just finished" flag,
    // and a "discard next fetched word" flag.
    int         m_rem  = 0;
    logic       m_done = 1'b0;
    logic       m_disc = 1'b0;
    logic       m_active, m_lu;
    int         m_left;
    logic [8:0] exp_v;

    always_comb begin
        m_active = (m_rem > 0) || (!m_done && start);
        m_left   = (m_rem > 0) ? m_rem : DC;
        m_lu     = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        exp_v    = 9'b0;
        if (rst) begin
            exp_v = 9'b00000_111_0;
        end else if (dmem) begin
            exp_v = {5'b11111, 3'b000, m_active};
        end else begin
            if (m_active)    exp_v = 9'b11100_001_1;
            else if (br)     exp_v = 9'b00000_110_0;
            else if (m_lu)   exp_v = 9'b11000_010_0;
            else if (imem)   exp_v = 9'b11000_000_0;
            if (m_disc && !imem) begin
                exp_v[7] = 1'b0;
                exp_v[3] = 1'b1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_disc <= 1'b0;
        end else if (!dmem) begin
            if (m_active) begin
                m_rem  <= m_left - 1;
                m_done <= (m_left == 1);
            end else begin
                m_done <= 1'b0;
            end
            if (!m_active && br && imem) m_disc <= 1'b1;
            else if (m_disc && !imem)    m_disc <= 1'b0;
        end
    end

    task automatic drive(input logic d, input logic i, input logic b, input logic s,
                         input logic m, input logic [4:0] r, input logic [4:0] a,
                         input logic ua, input logic [4:0] c, input logic uc);
        dmem = d; imem = i; br = b; start = s;
        mr = m; rd = r; rs1 = a; u1 = ua; rs2 = c; u2 = uc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0);
        #1;
        n_cmp++;
        if (obs !== 9'b00000_111_0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 9'b00000_111_0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 9'b0) begin
            n_fail++; $display("FAIL reset_release: got %b want %b", obs, 9'b0);
        end
    endtask

    task automatic test_load_use;
        logic [8:0] want [5] = '{9'b11000_010_0, 9'b0, 9'b0, 9'b11000_010_0, 9'b0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            case (c)
                0: drive(0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd7, 0);
                1: drive(0, 0, 0, 0, 0, 5'd5, 5'd5, 1, 5'd7, 0);
                2: drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
                3: drive(0, 0, 0, 0, 1, 5'd9, 5'd1, 0, 5'd9, 1);
                default: drive(0, 0, 0, 0, 1, 5'd9, 5'd9, 0, 5'd2, 1);
            endcase
            #1;
            n_cmp++;
            if (obs !== want[c] || obs !== exp_v) begin
                n_fail++; $display("FAIL load_use c%0d: got %b want %b", c, obs, want[c]);
            end
        end
    endtask

    task automatic test_divide;
        int busy_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            drive(0, 0, 0, (c < 5), 0, 5'd0, 5'd0, 0, 5'd0, 0);
            #1;
            busy_cnt += div_busy;
            n_cmp++;
            if (obs !== ((c < 4) ? 9'b11100_001_1 : 9'b0)) begin
                n_fail++; $display("FAIL divide c%0d: got %b want %b", c, obs,
                                   (c < 4) ? 9'b11100_001_1 : 9'b0);
            end
        end
        n_cmp++;
        if (busy_cnt != DC) begin
            n_fail++; $display("FAIL divide_len: got %0d want %0d", busy_cnt, DC);
        end
    endtask

    task automatic test_dmem_div;
        int stall_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            drive((c >= 2 && c <= 4), 0, 0, (c < 8), 0, 5'd0, 5'd0, 0, 5'd0, 0);
            #1;
            stall_cnt += pc_hold;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL dmem_div c%0d: got %b want %b", c, obs, exp_v);
            end
            if (c == 3) begin
                n_cmp++;
                if (obs !== 9'b11111_000_1) begin
                    n_fail++; $display("FAIL dmem_freeze: got %b want %b", obs, 9'b11111_000_1);
                end
            end
        end
        n_cmp++;
        if (stall_cnt != 7) begin
            n_fail++; $display("FAIL dmem_div_len: got %0d want 7", stall_cnt);
        end
    endtask

    task automatic test_branch_imem;
        logic [8:0] want [5] = '{9'b00000_110_0, 9'b11000_000_0, 9'b11000_000_0,
                                 9'b00000_100_0, 9'b0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(0, (c < 3), (c == 0), 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
            #1;
            n_cmp++;
            if (obs !== want[c] || obs !== exp_v) begin
                n_fail++; $display("FAIL branch_imem c%0d: got %b want %b", c, obs, want[c]);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [8:0] want [3] = '{9'b11111_000_0, 9'b11000_010_0, 9'b0};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive((c == 0), 0, 0, 0, (c < 2), 5'd12, 5'd1, 1, 5'd12, 1);
            #1;
            n_cmp++;
            if (obs !== want[c] || obs !== exp_v) begin
                n_fail++; $display("FAIL simultaneous c%0d: got %b want %b", c, obs, want[c]);
            end
        end
    endtask

    task automatic test_reset_mid_div;
        int busy_cnt = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            rst = (c == 2 || c == 3);
            drive(0, (c == 4), 0, (c < 4 || (c >= 5 && c < 10)), 0, 5'd0, 5'd0, 0, 5'd0, 0);
            #1;
            if (c >= 5) busy_cnt += div_busy;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL reset_mid_div c%0d: got %b want %b", c, obs, exp_v);
            end
            if (c == 2 || c == 4) begin
                n_cmp++;
                if (obs !== ((c == 2) ? 9'b00000_111_0 : 9'b11000_000_0)) begin
                    n_fail++; $display("FAIL reset_abort c%0d: got %b", c, obs);
                end
            end
        end
        n_cmp++;
        if (busy_cnt != DC) begin
            n_fail++; $display("FAIL div_after_reset_len: got %0d want %0d", busy_cnt, DC);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) < 2);
            drive(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            #1;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL random c%0d: got %b want %b", c, obs, exp_v);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_divide();
        test_dmem_div();
        test_branch_imem();
        test_simultaneous();
        test_reset_mid_div();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
